// File: rtl/i2c_pkg.sv
// Shared definitions for the BMP180-style I2C responder: FSM encoding,
// device constants and register-pointer arithmetic.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } i2c_state_e;

  localparam logic [6:0] BMP180_ADR = 7'h77;
  localparam logic [7:0] REG_ID     = 8'hD0;
  localparam logic [7:0] ID_VALUE   = 8'h55;

  // Register pointer is a plain 8-bit counter that wraps 0xFF -> 0x00.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes and glitch-filters raw SCL/SDA, then derives SCL edges and
// START/STOP bus conditions from the filtered levels.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0]            scl_sync_q, sda_sync_q;
  logic [FILTER_LEN-1:0] scl_hist_q, sda_hist_q;
  logic [FILTER_LEN-1:0] scl_hist_d, sda_hist_d;
  logic                  scl_q, sda_q, scl_prev_q, sda_prev_q;

  assign scl_hist_d = FILTER_LEN'({scl_hist_q, scl_sync_q[1]});
  assign sda_hist_d = FILTER_LEN'({sda_hist_q, sda_sync_q[1]});

  // Everything resets to the idle-bus level (high) so leaving reset with
  // the bus released never looks like an edge or a bus condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value
      // of its neighbour; blocking here would collapse the synchronizer chain.
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      if (&scl_hist_q)       scl_q <= 1'b1;
      else if (~|scl_hist_q) scl_q <= 1'b0;
      if (&sda_hist_q)       sda_q <= 1'b1;
      else if (~|sda_hist_q) sda_q <= 1'b0;
      scl_prev_q <= scl_q;
      sda_prev_q <= sda_q;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = scl_q & ~scl_prev_q;
  assign scl_fall_o = ~scl_q & scl_prev_q;
  // SCL must be stably high across the SDA transition for a bus condition.
  assign start_o    = sda_prev_q & ~sda_q & scl_q & scl_prev_q;
  assign stop_o     = ~sda_prev_q & sda_q & scl_q & scl_prev_q;

endmodule

// File: rtl/i2c_bmp180_responder.sv
// I2C target answering as a BMP180: address match + ACK, register pointer,
// burst writes and auto-incrementing burst reads through a register port.
module i2c_bmp180_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADR    = BMP180_ADR,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [3:0] state
);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .sda_o      (sda_f),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;
  logic       nack_q, nack_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_f};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
      nack_q      <= 1'b0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      nack_q      <= nack_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    nack_d      = nack_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;

    if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      // A partial byte is simply dropped: counter and flag restart here.
      state_d     = ADDR;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: begin
          if (!byte_done_q && scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == DEV_ADR) byte_done_d = 1'b1;
              else                         state_d     = IGNORE;
            end
          end else if (byte_done_q && scl_fall) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            busy_d      = 1'b1;
            state_d     = ADDR_ACK;
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (shift_q[0]) begin
              reg_re_d = 1'b1;
              state_d  = RDATA;
            end else begin
              state_d  = PTR;
            end
          end
        end

        PTR: begin
          if (!byte_done_q && scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_addr_d  = rx_byte;
              byte_done_d = 1'b1;
            end
          end else if (byte_done_q && scl_fall) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = PTR_ACK;
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WDATA;
          end
        end

        WDATA: begin
          if (!byte_done_q && scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              reg_wdata_d = rx_byte;
              reg_we_d    = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (byte_done_q && scl_fall) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            state_d     = WDATA_ACK;
          end
        end

        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d   = 1'b0;
            bit_cnt_d  = '0;
            reg_addr_d = ptr_next(reg_addr_q);
            state_d    = WDATA;
          end
        end

        RDATA: begin
          // reg_re_q high means the register file answered this cycle.
          if (reg_re_q) begin
            shift_d   = reg_rdata;
            sda_oe_d  = ~reg_rdata[7];
            bit_cnt_d = '0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            nack_d     = sda_f;
            reg_addr_d = ptr_next(reg_addr_q);
          end else if (scl_fall) begin
            if (nack_q) begin
              state_d  = IGNORE;
            end else begin
              reg_re_d = 1'b1;
              state_d  = RDATA;
            end
          end
        end

        default: ;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign state     = state_q;

endmodule

// File: tb/tb_i2c_bmp180_responder.sv
// Directed bench: a bit-banged I2C master on an open-drain SDA wire plus a
// register-file model; strobes are logged and checked against hand values.
module tb_i2c_bmp180_responder;
  import i2c_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl, m_sda, sda_line;
  logic       sda_oe, reg_we, reg_re, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0] state;

  logic [7:0] mem [0:255];
  logic [7:0] we_addr_q [$];
  logic [7:0] we_data_q [$];
  logic [7:0] re_addr_q [$];

  int         n_checks = 0;
  int         n_fail   = 0;
  logic       ack;
  logic [7:0] rd;

  always #5 clk = ~clk;

  assign sda_line  = m_sda & ~sda_oe;
  assign reg_rdata = mem[reg_addr];

  i2c_bmp180_responder #(
    .DEV_ADR    (7'h77),
    .FILTER_LEN (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (m_scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .state     (state)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b;    wait_clk(Q);
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic a);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(v);
      b[i] = v;
    end
    send_bit(a);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[REG_ID] = ID_VALUE;
    mem[8'hFE]  = 8'hA1;
    mem[8'hFF]  = 8'hB2;
    mem[8'h00]  = 8'hC3;
    reset = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;

    // Reset values
    wait_clk(3);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst reg_we", reg_we, 1'b0);
    check("rst reg_re", reg_re, 1'b0);
    check("rst reg_addr", reg_addr, 8'h00);
    check("rst reg_wdata", reg_wdata, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst state", state, 4'd0);
    reset = 1'b0;
    wait_clk(10);

    // ID read: pointer write, repeated START, single read with NACK
    clear_logs();
    i2c_start();
    write_byte(8'hEE, ack);
    check("id adr ack", ack, 1'b0);
    check("id busy", busy, 1'b1);
    write_byte(8'hD0, ack);
    check("id ptr ack", ack, 1'b0);
    check("id ptr value", reg_addr, 8'hD0);
    i2c_start();
    write_byte(8'hEF, ack);
    check("id rd adr ack", ack, 1'b0);
    read_byte(rd, 1'b1);
    check("id data", rd, 8'h55);
    check("id busy after nack", busy, 1'b1);
    check("id state after nack", state, 4'd9);
    i2c_stop();
    wait_clk(Q);
    check("id sda_oe after stop", sda_oe, 1'b0);
    check("id busy after stop", busy, 1'b0);
    check("id state after stop", state, 4'd0);
    check("id re count", re_addr_q.size(), 1);
    check("id re addr", re_addr_q[0], 8'hD0);
    check("id we count", we_addr_q.size(), 0);

    // Burst write with pointer increment
    clear_logs();
    i2c_start();
    write_byte(8'hEE, ack);
    check("bw ack adr", ack, 1'b0);
    write_byte(8'hF4, ack);
    check("bw ack ptr", ack, 1'b0);
    write_byte(8'h2E, ack);
    check("bw ack d0", ack, 1'b0);
    write_byte(8'h34, ack);
    check("bw ack d1", ack, 1'b0);
    i2c_stop();
    wait_clk(Q);
    check("bw we count", we_addr_q.size(), 2);
    check("bw we0 addr", we_addr_q[0], 8'hF4);
    check("bw we0 data", we_data_q[0], 8'h2E);
    check("bw we1 addr", we_addr_q[1], 8'hF5);
    check("bw we1 data", we_data_q[1], 8'h34);
    check("bw re count", re_addr_q.size(), 0);
    check("bw final ptr", reg_addr, 8'hF6);

    // Burst read across the 0xFF -> 0x00 wrap
    clear_logs();
    i2c_start();
    write_byte(8'hEE, ack);
    write_byte(8'hFE, ack);
    check("br ptr ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hEF, ack);
    check("br rd adr ack", ack, 1'b0);
    read_byte(rd, 1'b0);
    check("br data0", rd, 8'hA1);
    read_byte(rd, 1'b0);
    check("br data1", rd, 8'hB2);
    read_byte(rd, 1'b1);
    check("br data2", rd, 8'hC3);
    i2c_stop();
    wait_clk(Q);
    check("br re count", re_addr_q.size(), 3);
    check("br re0 addr", re_addr_q[0], 8'hFE);
    check("br re1 addr", re_addr_q[1], 8'hFF);
    check("br re2 addr", re_addr_q[2], 8'h00);
    check("br final ptr", reg_addr, 8'h01);
    check("br we count", we_addr_q.size(), 0);

    // Wrong address: no ACK, bus ignored until STOP
    clear_logs();
    i2c_start();
    write_byte(8'hA0, ack);
    check("wa no ack", ack, 1'b1);
    check("wa state", state, 4'd9);
    check("wa busy", busy, 1'b0);
    write_byte(8'h00, ack);
    check("wa data no ack", ack, 1'b1);
    check("wa state hold", state, 4'd9);
    i2c_stop();
    wait_clk(Q);
    check("wa state after stop", state, 4'd0);
    check("wa strobe count", we_addr_q.size() + re_addr_q.size(), 0);

    // Glitches are filtered; START mid-byte discards the partial byte
    clear_logs();
    m_sda = 1'b0; wait_clk(1);
    m_sda = 1'b1; wait_clk(Q);
    check("gl idle state", state, 4'd0);
    i2c_start();
    write_byte(8'hEE, ack);
    write_byte(8'hF4, ack);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(1);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
    check("gl wdata state", state, 4'd5);
    check("gl wdata busy", busy, 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    i2c_start();
    check("ab state addr", state, 4'd1);
    check("ab no we", we_addr_q.size(), 0);
    i2c_stop();
    wait_clk(Q);
    check("ab state idle", state, 4'd0);
    check("ab ptr kept", reg_addr, 8'hF4);
    check("ab no we after stop", we_addr_q.size(), 0);

    // Reset while the address ACK is being driven low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(rd_bit(8'hEE, i));
    check("rs pre ack drive", sda_oe, 1'b1);
    check("rs pre state", state, 4'd2);
    reset = 1'b1;
    #1;
    check("rs sda_oe async", sda_oe, 1'b0);
    check("rs busy", busy, 1'b0);
    check("rs reg_addr", reg_addr, 8'h00);
    check("rs state", state, 4'd0);
    check("rs strobes", {reg_we, reg_re}, 2'b00);
    m_sda = 1'b1;
    m_scl = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(2 * Q);
    check("rs idle after release", state, 4'd0);
    check("rs sda released", sda_oe, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic rd_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
